// File: rtl/stall_ctrl_pkg.sv
// Shared constants for the pipeline stall controller: Tuse/Tnew encoding and
// mult/div latency defaults.
package stall_ctrl_pkg;
    localparam int T_W = 2;
    localparam logic [T_W-1:0] TUSE_NONE = 2'd3;
    localparam int MULT_CYC_DEF = 5;
    localparam int DIV_CYC_DEF = 10;
    localparam int MD_CNT_W = 4;
endpackage

// File: rtl/stall_ctrl_md_busy_cnt.sv
// Mult/div busy tracker: counts down the remaining busy cycles after an issue.
module md_busy_cnt
    import stall_ctrl_pkg::*;
#(
    parameter int MULT_CYC = MULT_CYC_DEF,
    parameter int DIV_CYC  = DIV_CYC_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic i_start,
    input  logic i_div,
    output logic o_busy
);
    logic [MD_CNT_W-1:0] r_cnt;

    // A new issue always reloads, so the latest start wins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (i_start) begin
            r_cnt <= i_div ? MD_CNT_W'(DIV_CYC) : MD_CNT_W'(MULT_CYC);
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_busy = i_start | (r_cnt != '0);
endmodule

// File: rtl/stall_ctrl.sv
// Decode-stage stall controller: register hazards against E/M plus mult/div
// busy interlock, with a saturating stall-cycle counter.
module stall_ctrl
    import stall_ctrl_pkg::*;
#(
    parameter int MULT_CYC = MULT_CYC_DEF,
    parameter int DIV_CYC  = DIV_CYC_DEF
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [4:0]     D_rs,
    input  logic [4:0]     D_rt,
    input  logic [T_W-1:0] D_Tuse_rs,
    input  logic [T_W-1:0] D_Tuse_rt,
    input  logic [4:0]     E_A3,
    input  logic [4:0]     M_A3,
    input  logic [T_W-1:0] E_Tnew,
    input  logic [T_W-1:0] M_Tnew,
    input  logic           D_is_md,
    input  logic           E_md_start,
    input  logic           E_md_div,
    output logic           F_D_RegWE,
    output logic           PC_WE,
    output logic           D_E_clear,
    output logic           md_busy,
    output logic [31:0]    stall_cnt
);
    logic        w_rs_stall;
    logic        w_rt_stall;
    logic        w_md_stall;
    logic        w_stall;
    logic        w_md_busy;
    logic [31:0] r_stall_cnt;

    // Register 0 is never a real producer, so it cannot create a hazard.
    function automatic logic src_hazard(
        input logic [4:0]     src,
        input logic [T_W-1:0] tuse,
        input logic [4:0]     e_a3,
        input logic [T_W-1:0] e_tnew,
        input logic [4:0]     m_a3,
        input logic [T_W-1:0] m_tnew
    );
        logic hit_e;
        logic hit_m;
        hit_e = (src == e_a3) && (e_tnew > tuse);
        hit_m = (src == m_a3) && (m_tnew > tuse);
        return (src != 5'd0) && (tuse != TUSE_NONE) && (hit_e || hit_m);
    endfunction

    md_busy_cnt #(
        .MULT_CYC (MULT_CYC),
        .DIV_CYC  (DIV_CYC)
    ) u_md_busy_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_start (E_md_start),
        .i_div   (E_md_div),
        .o_busy  (w_md_busy)
    );

    assign w_rs_stall = src_hazard(D_rs, D_Tuse_rs, E_A3, E_Tnew, M_A3, M_Tnew);
    assign w_rt_stall = src_hazard(D_rt, D_Tuse_rt, E_A3, E_Tnew, M_A3, M_Tnew);
    assign w_md_stall = D_is_md & w_md_busy;
    assign w_stall    = w_rs_stall | w_rt_stall | w_md_stall;

    assign F_D_RegWE = ~w_stall;
    assign PC_WE     = ~w_stall;
    assign D_E_clear = w_stall;
    assign md_busy   = w_md_busy;
    assign stall_cnt = r_stall_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end
endmodule
